// File: rtl/spi_sram_pkg.sv
// Shared types and defaults for the SPI-to-SRAM bridge.
package spi_sram_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WR_DATA, RD_FETCH, RD_DATA, IGNORE
  } state_t;
endpackage

// File: rtl/spi_shift8.sv
// Serial-in / parallel-load / serial-out shift register, MSB first.
module spi_shift8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         sh,
  input  logic         sin,
  output logic [W-1:0] q
);
  // parallel load wins over shift; shift moves toward the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
    else if (sh) q <= {q[W-2:0], sin};
  end
endmodule

// File: rtl/spi_sram_ctrl.sv
// SPI slave bridging write (0x02) / read (0x03) bursts onto a simple SRAM port.
module spi_sram_ctrl #(
  parameter int         AW       = spi_sram_pkg::DEF_AW,
  parameter int         DW       = spi_sram_pkg::DEF_DW,
  parameter logic [7:0] OP_WRITE = spi_sram_pkg::OP_WRITE,
  parameter logic [7:0] OP_READ  = spi_sram_pkg::OP_READ
) (
  input  logic          sck,
  input  logic          rst,
  input  logic          cs_n,
  input  logic          sdi,
  output logic          sdo,
  output logic          lA,
  output logic          dA,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  output logic          sram_we,
  output logic          sram_re,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy
);
  import spi_sram_pkg::*;

  state_t        state, nstate;
  logic [2:0]    cnt;
  logic          rd_q;
  logic [DW-1:0] in_q, out_q, byte_in;
  logic          last, in_sh, out_sh;

  // byte completing on this edge: seven held bits plus the one being sampled
  assign byte_in = {in_q[DW-2:0], sdi};
  assign last    = (cnt == 3'd7);

  spi_shift8 #(.W(DW)) u_in (
    .clk(sck), .rst_n(rst), .ld(1'b0), .d('0), .sh(in_sh), .sin(sdi), .q(in_q)
  );

  // output byte loads whenever a read strobe is up, so bytes chain with no gap
  spi_shift8 #(.W(DW)) u_out (
    .clk(sck), .rst_n(rst), .ld(sram_re), .d(sram_rdata), .sh(out_sh), .sin(1'b0), .q(out_q)
  );

  // state register
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // next state and state-decoded outputs
  always_comb begin
    nstate  = state;
    sram_re = 1'b0;
    dA      = 1'b0;
    sdo     = 1'b0;
    in_sh   = 1'b0;
    out_sh  = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE:     begin nstate = CMD; in_sh = !cs_n; end
      CMD:      begin
                  in_sh = !cs_n;
                  if (last)
                    nstate = (byte_in == DW'(OP_WRITE) || byte_in == DW'(OP_READ)) ? ADDR : IGNORE;
                end
      ADDR:     begin in_sh = !cs_n; if (last) nstate = rd_q ? RD_FETCH : WR_DATA; end
      WR_DATA:  begin in_sh = !cs_n; dA = 1'b1; end
      RD_FETCH: begin sram_re = 1'b1; nstate = RD_DATA; end
      RD_DATA:  begin dA = 1'b1; sdo = out_q[DW-1]; out_sh = 1'b1; sram_re = last; end
      default:  nstate = state;
    endcase
    if (cs_n) nstate = IDLE;
  end

  // bit counter, address/data registers and SRAM write/latch strobes
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      rd_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      lA         <= 1'b0;
    end else begin
      lA      <= 1'b0;
      sram_we <= 1'b0;
      if (cs_n) cnt <= '0;
      else if (state != RD_FETCH && state != IGNORE) cnt <= cnt + 3'd1;
      // a write pulse has just been seen by the SRAM: step to the next location
      if (sram_we) sram_addr <= sram_addr + AW'(1);
      if (!cs_n) begin
        case (state)
          CMD:     if (last) rd_q <= (byte_in == DW'(OP_READ));
          ADDR:    if (last) begin sram_addr <= AW'(byte_in); lA <= 1'b1; end
          WR_DATA: if (last) begin sram_wdata <= byte_in; sram_we <= 1'b1; end
          // step one cycle early so the next fetch lands on the byte's last bit
          RD_DATA: if (cnt == 3'd6) sram_addr <= sram_addr + AW'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Randomized bench for spi_sram_ctrl against a byte-level SPI/SRAM model.
module tb_spi_sram_ctrl;
  logic       sck = 1'b0, rst = 1'b0, cs_n = 1'b1, sdi = 1'b0;
  logic       sdo, lA, dA, sram_we, sram_re, busy;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;

  logic [7:0]  mem [256];
  logic [7:0]  mem_ref [256];
  logic [15:0] wq[$];
  int          re_cnt = 0, both_cnt = 0;
  int          tests = 0, fails = 0;

  spi_sram_ctrl dut (
    .sck(sck), .rst(rst), .cs_n(cs_n), .sdi(sdi), .sdo(sdo), .lA(lA), .dA(dA),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_re(sram_re), .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 sck = ~sck;
  assign sram_rdata = mem[sram_addr];

  // SRAM side: capture writes and count strobes mid-cycle
  always @(negedge sck) begin
    if (sram_we) begin
      wq.push_back({sram_addr, sram_wdata});
      mem[sram_addr] = sram_wdata;
    end
    if (sram_re) re_cnt++;
    if (sram_we && sram_re) both_cnt++;
  end

  task automatic xfer_bit(input logic b);
    @(negedge sck); cs_n = 1'b0; sdi = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) xfer_bit(b[i]);
  endtask

  task automatic end_cs();
    @(negedge sck); cs_n = 1'b1; sdi = 1'b0;
  endtask

  task automatic settle();
    @(negedge sck); #1;
  endtask

  task automatic test_reset();
    #12;
    tests++; if ({sdo, lA, dA, sram_we, sram_re, busy} !== 6'b0) begin fails++;
      $display("FAIL reset_ctl: got %b want 000000", {sdo, lA, dA, sram_we, sram_re, busy}); end
    tests++; if (sram_addr !== 8'h00 || sram_wdata !== 8'h00) begin fails++;
      $display("FAIL reset_regs: addr=%h wdata=%h want 00/00", sram_addr, sram_wdata); end
    @(negedge sck); rst = 1'b1;
    repeat (2) @(negedge sck);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_write();
    logic [7:0] d;
    d = 8'hA5;
    wq.delete();
    send_byte(8'h02); send_byte(8'h10);
    @(negedge sck);
    tests++; if (lA !== 1'b1 || sram_addr !== 8'h10 || dA !== 1'b1) begin fails++;
      $display("FAIL write_la: lA=%b addr=%h dA=%b want 1/10/1", lA, sram_addr, dA); end
    sdi = d[7];
    @(negedge sck);
    tests++; if (lA !== 1'b0) begin fails++; $display("FAIL write_la_width: lA=%b want 0", lA); end
    sdi = d[6];
    for (int i = 5; i >= 0; i--) xfer_bit(d[i]);
    end_cs(); settle();
    tests++; if (wq.size() != 1 || wq[0] !== 16'h10A5) begin fails++;
      $display("FAIL write_we: n=%0d first=%h want 1 x 10a5", wq.size(), wq.size() ? wq[0] : 16'h0); end
    mem_ref[8'h10] = 8'hA5;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_end: busy=%b want 0", busy); end
  endtask

  task automatic test_burst_wrap();
    wq.delete();
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
    end_cs(); settle();
    tests++; if (wq.size() != 2 || wq[0] !== 16'hFF11 || wq[1] !== 16'h0022) begin fails++;
      $display("FAIL burst_wrap: n=%0d e0=%h e1=%h want ff11,0022", wq.size(),
               wq.size() > 0 ? wq[0] : 16'h0, wq.size() > 1 ? wq[1] : 16'h0); end
    mem_ref[8'hFF] = 8'h11; mem_ref[8'h00] = 8'h22;
  endtask

  // read n bytes from a; compares serial data to the reference memory
  task automatic do_read(input string nm, input logic [7:0] a, input int n);
    logic [7:0] got [4];
    int re0;
    logic ok;
    re0 = re_cnt;
    send_byte(8'h03); send_byte(a);
    @(negedge sck); sdi = $urandom;
    for (int k = 0; k < 8 * n; k++) begin
      @(negedge sck); sdi = $urandom;
      got[k / 8][7 - (k % 8)] = sdo;
    end
    cs_n = 1'b1;
    settle();
    ok = 1'b1;
    for (int i = 0; i < n; i++) if (got[i] !== mem_ref[8'(a + i)]) ok = 1'b0;
    tests++; if (!ok) begin fails++;
      $display("FAIL %s_data: addr=%h first=%h want %h", nm, a, got[0], mem_ref[a]); end
    tests++; if (re_cnt - re0 != n + 1) begin fails++;
      $display("FAIL %s_re: pulses=%0d want %0d", nm, re_cnt - re0, n + 1); end
  endtask

  task automatic test_read();
    mem[8'h20] = 8'h3C; mem_ref[8'h20] = 8'h3C;
    do_read("read", 8'h20, 2);
  endtask

  task automatic test_bad_opcode();
    int re0;
    wq.delete(); re0 = re_cnt;
    send_byte(8'h7E); send_byte(8'($urandom)); send_byte(8'($urandom));
    @(negedge sck);
    tests++; if (busy !== 1'b1 || dA !== 1'b0) begin fails++;
      $display("FAIL bad_busy: busy=%b dA=%b want 1/0", busy, dA); end
    cs_n = 1'b1; settle();
    tests++; if (wq.size() != 0 || re_cnt != re0 || busy !== 1'b0) begin fails++;
      $display("FAIL bad_strobes: we=%0d re=%0d busy=%b want 0/0/0", wq.size(), re_cnt - re0, busy); end
  endtask

  task automatic test_abort();
    wq.delete();
    send_byte(8'h02); send_byte(8'h33);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1);
    end_cs(); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_pre: busy=%b want 1", busy); end
    @(posedge sck); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: busy=%b want 0", busy); end
    repeat (3) @(negedge sck);
    tests++; if (wq.size() != 0) begin fails++; $display("FAIL abort_we: writes=%0d want 0", wq.size()); end
  endtask

  task automatic test_reset_mid_read();
    wq.delete();
    send_byte(8'h03); send_byte(8'h40);
    repeat (4) @(negedge sck);
    @(posedge sck); #2; rst = 1'b0; #1;
    tests++; if ({sdo, lA, dA, sram_we, sram_re, busy} !== 6'b0 || sram_addr !== 8'h00 || sram_wdata !== 8'h00) begin fails++;
      $display("FAIL rst_mid: ctl=%b addr=%h wdata=%h want 0", {sdo, lA, dA, sram_we, sram_re, busy}, sram_addr, sram_wdata); end
    cs_n = 1'b1;
    @(negedge sck); rst = 1'b1;
    repeat (3) @(negedge sck);
    tests++; if (busy !== 1'b0 || wq.size() != 0) begin fails++;
      $display("FAIL rst_after: busy=%b writes=%0d want 0/0", busy, wq.size()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int kind, n, p, re0;
      logic [7:0] a, op;
      logic [7:0] d [4];
      logic [15:0] exp[$];
      logic ok;
      kind = $urandom_range(0, 2); n = $urandom_range(1, 4); a = 8'($urandom);
      if (kind == 0) begin
        wq.delete(); exp.delete();
        p = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 7) : 0;
        send_byte(8'h02); send_byte(a);
        for (int i = 0; i < n; i++) begin
          d[i] = 8'($urandom); send_byte(d[i]);
          exp.push_back({8'(a + i), d[i]});
          mem_ref[8'(a + i)] = d[i];
        end
        for (int i = 0; i < p; i++) xfer_bit($urandom);
        end_cs(); settle();
        ok = (wq.size() == exp.size());
        if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
        tests++; if (!ok) begin fails++;
          $display("FAIL rnd_write[%0d]: n=%0d got=%0d addr=%h", t, exp.size(), wq.size(), a); end
      end else if (kind == 1) begin
        do_read("rnd_read", a, n);
      end else begin
        wq.delete(); re0 = re_cnt;
        do op = 8'($urandom); while (op == 8'h02 || op == 8'h03);
        send_byte(op);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
        end_cs(); settle();
        tests++; if (wq.size() != 0 || re_cnt != re0) begin fails++;
          $display("FAIL rnd_bad[%0d]: op=%h we=%0d re=%0d want 0/0", t, op, wq.size(), re_cnt - re0); end
      end
      repeat ($urandom_range(0, 2)) @(negedge sck);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom); mem_ref[i] = mem[i];
    end
    test_reset();
    test_write();
    test_burst_wrap();
    test_read();
    test_bad_opcode();
    test_abort();
    test_reset_mid_read();
    test_random();
    tests++; if (both_cnt != 0) begin fails++;
      $display("FAIL we_re_overlap: cycles=%0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_sram_ctrl.md
SPI_SRAM_CTRL -- requirements
Module: spi_sram_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
  sck  in  1  serial clock; the block's single clock; all state changes on its rising edge
  rst  in  1  reset; asynchronous, active-low
  cs_n  in  1  chip select, active-low; sampled on rising sck
  sdi  in  1  serial data in, MSB first; sampled on rising sck
  sdo  out  1  serial read data out, MSB first
  lA  out  1  latch-address strobe to datapath; high for the one cycle the address register loads
  dA  out  1  data-phase indicator to datapath; high while in WR_DATA or RD_DATA
  sram_addr  out  8  registered SRAM address
  sram_wdata  out  8  registered SRAM write data
  sram_we  out  1  SRAM write strobe, one-cycle pulse
  sram_re  out  1  SRAM read strobe, one-cycle pulse
  sram_rdata  in  8  SRAM read data; combinational, valid in the cycle sram_re is high
  busy  out  1  high whenever state is not IDLE
REQ-002 Parameters (name, default, meaning): AW, 8, address width; DW, 8, data width; OP_WRITE, 8'h02, write opcode; OP_READ, 8'h03, read opcode.

Function
REQ-003 States SHALL be IDLE, CMD, ADDR, WR_DATA, RD_FETCH, RD_DATA, IGNORE; a 3-bit bit counter SHALL count sampled bits within each byte, wrapping 7->0.
REQ-004 IDLE -> CMD when cs_n sampled low; the sdi bit on that same edge SHALL be the first command bit.
REQ-005 CMD: after 8 bits, opcode == OP_WRITE or OP_READ -> ADDR; any other opcode -> IGNORE.
REQ-006 ADDR: after the 8th bit, sram_addr SHALL load the assembled byte and lA SHALL be high in the following cycle; write -> WR_DATA, read -> RD_FETCH.
REQ-007 WR_DATA: after the 8th bit, sram_wdata SHALL load the byte and sram_we SHALL pulse high for exactly the next cycle with that address/data; sram_addr SHALL then increment (0xFF wraps to 0x00) and WR_DATA SHALL continue for the next byte.
REQ-008 RD_FETCH lasts exactly one cycle with sram_re high; at its closing edge sram_rdata SHALL load the output shift register; -> RD_DATA.
REQ-009 RD_DATA: sdo SHALL present bit 7 in the first cycle, then one bit per cycle MSB first; sdi ignored; after 8 bits sram_addr SHALL increment (wrap 0xFF->0x00), sram_re SHALL pulse one cycle and the new byte SHALL load seamlessly, with no gap cycle between bytes.
REQ-010 IGNORE: sdi discarded, no SRAM strobes, until cs_n high.
REQ-011 cs_n sampled high in any state SHALL force IDLE at that edge; a partial byte SHALL be discarded and SHALL NOT produce sram_we; a strobe already pulsing completes its single cycle.
REQ-012 sdo SHALL be 0 outside RD_DATA; dA high only in WR_DATA and RD_DATA; sram_we and sram_re SHALL never be high in the same cycle.

Reset
REQ-013 rst low SHALL immediately force: state IDLE, bit counter 0, sram_addr 0, sram_wdata 0, shift registers 0, sdo 0, lA 0, dA 0, sram_we 0, sram_re 0, busy 0.
REQ-014 Reset mid-transaction SHALL abandon it without any SRAM strobe; after release the block SHALL wait for a fresh cs_n low in IDLE.

Structure
REQ-015 State enum, opcodes OP_WRITE/OP_READ and AW/DW defaults SHALL live in shared package spi_sram_pkg.
REQ-016 The 8-bit serial-in/parallel-load/serial-out register SHALL be sub-module spi_shift8, instanced once for input and once for output.

Verification
REQ-017 Write: cs_n low, shift 0x02, 0x10, 0xA5 -> lA one cycle after 16th bit, sram_we one pulse with addr 0x10, wdata 0xA5.
REQ-018 Burst write with wrap: 0x02, 0xFF, 0x11, 0x22 -> sram_we at addr 0xFF data 0x11, then addr 0x00 data 0x22.
REQ-019 Read: SRAM model holds 0x3C at 0x20; shift 0x03, 0x20 -> sram_re one cycle (RD_FETCH), then sdo = 0,0,1,1,1,1,0,0 on consecutive cycles; second byte from 0x21 follows with no gap.
REQ-020 Bad opcode 0x7E then 16 bits -> IGNORE, no sram_we/sram_re, busy high until cs_n high.
REQ-021 Abort: cs_n high after 4 data bits of a write -> IDLE next edge, no sram_we.
REQ-022 Async reset: assert rst low mid RD_DATA between sck edges -> all outputs 0 immediately, busy 0.
